// File: rtl/led_panel_pkg.sv
// Shared constants and types for the LED panel scanner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package led_panel_pkg;

  localparam int PANEL_W   = 32;
  localparam int PANEL_H   = 16;
  localparam int ROW_PAIRS = 8;

  // One bit per colour channel, ordered {R,G,B}.
  typedef logic [2:0] pixel_t;

  typedef enum logic [2:0] {
    SHIFT_LO,
    SHIFT_HI,
    BLANK,
    LATCH,
    DISPLAY
  } scan_state_e;

endpackage

// File: rtl/led_framebuffer.sv
// Double-buffered 32x16 framebuffer, 1 bit per channel, with deferred front/back swap.
// Latency: a write is stored on the strobe edge; reads are combinational from the front buffer.
// Backpressure: none; writes and swap requests are accepted every cycle.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset (clears both buffers)
//   wr_en/wr_x/wr_y/wr_pix   pixel write into the back buffer
//   swap_req           request a swap; held pending until frame_start
//   frame_start        strobe on the edge that starts row 0, column 0 of a new frame
//   rd_row/rd_col      scan position; rd_top = row, rd_bot = row + 8
module led_framebuffer
  import led_panel_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_x,
  input  logic [3:0] wr_y,
  input  logic [2:0] wr_pix,
  input  logic       swap_req,
  input  logic       frame_start,
  input  logic [2:0] rd_row,
  input  logic [4:0] rd_col,
  output logic [2:0] rd_top,
  output logic [2:0] rd_bot
);

  localparam int DEPTH = PANEL_W * PANEL_H;

  // Buffer index 0/1, then pixel address {y, x}.
  pixel_t [1:0][DEPTH-1:0] fb_q, fb_d;
  logic front_q, front_d;
  logic pending_q, pending_d;
  logic swap_now;

  always_comb begin
    swap_now  = pending_q & frame_start;
    front_d   = front_q ^ swap_now;
    // A request arriving on the swap edge itself is kept for the following frame.
    pending_d = swap_req | (pending_q & ~swap_now);
    fb_d      = fb_q;
    // Writes always target the buffer that is the back buffer before this edge,
    // so a write issued alongside the swap lands in the frame being swapped in.
    if (wr_en) begin
      fb_d[~front_q][{wr_y, wr_x}] = wr_pix;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fb_q      <= '0;
      front_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      fb_q      <= fb_d;
      front_q   <= front_d;
      pending_q <= pending_d;
    end
  end

  assign rd_top = fb_q[front_q][{1'b0, rd_row, rd_col}];
  assign rd_bot = fb_q[front_q][{1'b1, rd_row, rd_col}];

endmodule

// File: rtl/led_panel_scanner.sv
// Scans a double-buffered framebuffer out to a 32x16 RGB panel, one row pair at a time.
// Latency: all outputs registered, one cycle behind the scan state; swaps take effect at the next frame start.
// Backpressure: none; pixel writes and update requests are accepted in every state.
//
// Ports:
//   clk, reset                          system clock, synchronous active-high reset
//   x_address, y_address, color,
//   new_data                            pixel write into the back buffer
//   update_panel                        request a buffer swap at the next frame boundary
//   led_rgb1/led_rgb2                   top-half / bottom-half pixel being shifted
//   led_abc                             row-pair address, updated with the latch pulse
//   led_clk, led_latch, led_oe          panel shift clock, latch strobe, active-low enable
module led_panel_scanner
  import led_panel_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned DISPLAY_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] x_address,
  input  logic [3:0] y_address,
  input  logic [2:0] color,
  input  logic       new_data,
  input  logic       update_panel,
  output logic [2:0] led_rgb1,
  output logic [2:0] led_rgb2,
  output logic [2:0] led_abc,
  output logic       led_clk,
  output logic       led_latch,
  output logic       led_oe
);

  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [15:0] DISP_LAST = 16'(DISPLAY_CYCLES - 1);
  localparam logic [4:0]  COL_LAST  = 5'(PANEL_W - 1);
  localparam logic [2:0]  ROW_LAST  = 3'(ROW_PAIRS - 1);

  scan_state_e state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  col_q, col_d;
  logic [2:0]  row_q, row_d;
  logic [15:0] disp_q, disp_d;

  logic [2:0] rgb1_q, rgb1_d;
  logic [2:0] rgb2_q, rgb2_d;
  logic [2:0] abc_q, abc_d;
  logic       lclk_q, lclk_d;
  logic       latch_q, latch_d;
  logic       oe_q, oe_d;

  logic       div_done, disp_done, frame_start;
  logic [2:0] pix_top, pix_bot;

  assign div_done  = (div_q == DIV_LAST);
  assign disp_done = (disp_q == DISP_LAST);
  // True on the edge that moves from the last row's display into row 0, column 0.
  assign frame_start = (state_q == DISPLAY) && disp_done && (row_q == ROW_LAST);

  led_framebuffer u_fb (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (new_data),
    .wr_x        (x_address),
    .wr_y        (y_address),
    .wr_pix      (color),
    .swap_req    (update_panel),
    .frame_start (frame_start),
    .rd_row      (row_q),
    .rd_col      (col_q),
    .rd_top      (pix_top),
    .rd_bot      (pix_bot)
  );

  // State and counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SHIFT_LO;
      div_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      col_q   <= col_d;
      row_q   <= row_d;
      disp_q  <= disp_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    col_d   = col_q;
    row_d   = row_q;
    disp_d  = disp_q;
    unique case (state_q)
      SHIFT_LO: begin
        if (div_done) begin
          div_d   = '0;
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT_HI: begin
        if (div_done) begin
          div_d   = '0;
          // Column wraps to 0 after the last one, ready for the next row.
          col_d   = col_q + 5'd1;
          state_d = (col_q == COL_LAST) ? BLANK : SHIFT_LO;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      BLANK: begin
        state_d = LATCH;
      end
      LATCH: begin
        disp_d  = '0;
        state_d = DISPLAY;
      end
      DISPLAY: begin
        if (disp_done) begin
          row_d   = row_q + 3'd1;
          col_d   = '0;
          state_d = SHIFT_LO;
        end else begin
          disp_d = disp_q + 16'd1;
        end
      end
      default: begin
        state_d = SHIFT_LO;
      end
    endcase
  end

  // Output decode from the current state; registered below, so the pins
  // trail the state by one cycle.
  always_comb begin
    rgb1_d  = '0;
    rgb2_d  = '0;
    abc_d   = abc_q;
    lclk_d  = 1'b0;
    latch_d = 1'b0;
    oe_d    = 1'b1;
    unique case (state_q)
      SHIFT_LO: begin
        rgb1_d = pix_top;
        rgb2_d = pix_bot;
      end
      SHIFT_HI: begin
        rgb1_d = pix_top;
        rgb2_d = pix_bot;
        lclk_d = 1'b1;
      end
      LATCH: begin
        latch_d = 1'b1;
        abc_d   = row_q;
      end
      DISPLAY: begin
        oe_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb1_q  <= '0;
      rgb2_q  <= '0;
      abc_q   <= '0;
      lclk_q  <= 1'b0;
      latch_q <= 1'b0;
      oe_q    <= 1'b1;
    end else begin
      rgb1_q  <= rgb1_d;
      rgb2_q  <= rgb2_d;
      abc_q   <= abc_d;
      lclk_q  <= lclk_d;
      latch_q <= latch_d;
      oe_q    <= oe_d;
    end
  end

  assign led_rgb1  = rgb1_q;
  assign led_rgb2  = rgb2_q;
  assign led_abc   = abc_q;
  assign led_clk   = lclk_q;
  assign led_latch = latch_q;
  assign led_oe    = oe_q;

endmodule
